// File: rtl/booth_nonrestoring_divider.sv
// Sequential signed divider: non-restoring radix-2 core, one quotient bit per clock.
// Operands arrive on a shared bus after start; result is {remainder, quotient}.
module booth_nonrestoring_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    output logic [2*WIDTH-1:0] out,
    output logic               done,
    output logic               busy,
    output logic               div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        StIdle, StLoadDvd, StLoadDvs, StIter, StFix, StSign, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH+1:0]   p_q, p_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH:0]     d_q, d_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               dvd_neg_q, dvd_neg_d;
    logic               dvs_neg_q, dvs_neg_d;
    logic               zero_q, zero_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     in_mag;
    logic [WIDTH+1:0]   p_sh, p_step, d_ext;
    logic [WIDTH-1:0]   quot, rem, dvd_orig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            p_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            q_q       <= q_d;
            d_q       <= d_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            zero_q    <= zero_d;
            dbz_q     <= dbz_d;
        end
    end

    always_comb begin
        // Magnitude needs WIDTH+1 bits so the most negative operand stays exact.
        in_mag   = data_in[WIDTH-1] ? ({1'b0, ~data_in} + (WIDTH+1)'(1)) : {1'b0, data_in};
        d_ext    = {1'b0, d_q};
        p_sh     = {p_q[WIDTH:0], q_q[WIDTH-1]};
        p_step   = p_q[WIDTH+1] ? (p_sh + d_ext) : (p_sh - d_ext);
        quot     = (dvd_neg_q ^ dvs_neg_q) ? -q_q : q_q;
        rem      = dvd_neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
        // On divide-by-zero Q still holds the untouched dividend magnitude.
        dvd_orig = dvd_neg_q ? -q_q : q_q;

        state_d   = state_q;
        p_d       = p_q;
        q_d       = q_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        zero_d    = zero_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StLoadDvd;
            end
            StLoadDvd: begin
                dvd_neg_d = data_in[WIDTH-1];
                q_d       = in_mag[WIDTH-1:0];
                state_d   = StLoadDvs;
            end
            StLoadDvs: begin
                dvs_neg_d = data_in[WIDTH-1];
                d_d       = in_mag;
                p_d       = '0;
                cnt_d     = CntW'(WIDTH);
                zero_d    = (data_in == '0);
                state_d   = (data_in == '0) ? StSign : StIter;
            end
            StIter: begin
                p_d     = p_step;
                q_d     = {q_q[WIDTH-2:0], ~p_step[WIDTH+1]};
                cnt_d   = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) state_d = StFix;
            end
            StFix: begin
                if (p_q[WIDTH+1]) p_d = p_q + d_ext;
                state_d = StSign;
            end
            StSign: begin
                if (zero_q) begin
                    out_d = {dvd_orig, {WIDTH{1'b1}}};
                    dbz_d = 1'b1;
                end else begin
                    out_d = {rem, quot};
                    dbz_d = 1'b0;
                end
                state_d = StDone;
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign out         = out_q;
    assign done        = (state_q == StDone);
    assign busy        = (state_q != StIdle) && (state_q != StDone);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_booth_nonrestoring_divider.sv
// Directed-vector bench for booth_nonrestoring_divider (WIDTH=16).
module tb_booth_nonrestoring_divider;

    localparam int unsigned WIDTH = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [WIDTH-1:0]   data_in = '0;
    logic [2*WIDTH-1:0] out;
    logic               done;
    logic               busy;
    logic               div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    booth_nonrestoring_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .out         (out),
        .done        (done),
        .busy        (busy),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one division from IDLE; leaves start high in DONE.
    task automatic do_div(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                          input logic [31:0] exp_out, input logic exp_dbz, input int exp_lat);
        int acc;
        int n;
        @(negedge clk) start = 1'b1;
        data_in = 16'h5A5A;
        @(posedge clk) #1 acc = cyc;
        @(negedge clk) data_in = dvd;
        @(negedge clk) data_in = dvs;
        check({tag, ".busy"}, 64'(busy), 64'(1));
        @(negedge clk) data_in = 16'hDEAD;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".done"}, 64'(done), 64'(1));
        check({tag, ".lat"}, 64'(cyc - acc), 64'(exp_lat));
        check({tag, ".out"}, 64'(out), 64'(exp_out));
        check({tag, ".dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    endtask

    task automatic drop_start(input string tag);
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        check({tag, ".done_clr"}, 64'(done), 64'(0));
        check({tag, ".dbz_clr"}, 64'(div_by_zero), 64'(0));
    endtask

    initial begin
        logic [31:0] held;
        int n;
        repeat (3) @(negedge clk);
        check("rst.out", 64'(out), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.dbz", 64'(div_by_zero), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        do_div("p100_7", 16'd100, 16'd7, 32'h0002_000E, 1'b0, 20);
        drop_start("p100_7");

        do_div("m13_25", 16'hFFF3, 16'h0019, 32'hFFF3_0000, 1'b0, 20);
        held = out;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!done || busy || out !== held) n++;
        end
        check("hold.stable", 64'(n), 64'(0));
        drop_start("m13_25");

        do_div("m100_7", 16'hFF9C, 16'd7, 32'hFFFE_FFF2, 1'b0, 20);
        drop_start("m100_7");
        do_div("p100_m7", 16'd100, 16'hFFF9, 32'h0002_FFF2, 1'b0, 20);
        drop_start("p100_m7");

        do_div("dbz", 16'd5, 16'd0, 32'h0005_FFFF, 1'b1, 3);
        drop_start("dbz");
        check("dbz.idle_busy", 64'(busy), 64'(0));

        do_div("ovf", 16'h8000, 16'hFFFF, 32'h0000_8000, 1'b0, 20);
        drop_start("ovf");
        do_div("min_1", 16'h8000, 16'h0001, 32'h0000_8000, 1'b0, 20);
        drop_start("min_1");
        do_div("max_max", 16'h7FFF, 16'h7FFF, 32'h0000_0001, 1'b0, 20);
        drop_start("max_max");

        // Abort mid-iteration: outputs clear asynchronously.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) data_in = 16'd1000;
        @(negedge clk) data_in = 16'd3;
        repeat (6) @(negedge clk);
        check("abort.busy_pre", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("abort.out", 64'(out), 64'(0));
        check("abort.done", 64'(done), 64'(0));
        check("abort.busy", 64'(busy), 64'(0));
        check("abort.dbz", 64'(div_by_zero), 64'(0));
        start = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        do_div("post_rst", 16'd100, 16'd7, 32'h0002_000E, 1'b0, 20);
        drop_start("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
